// File: rtl/memaccess_pkg.sv
// Shared types and helpers for the two-port memory access arbiter.
package memaccess_pkg;

    localparam int ARB_FIXED  = 0;
    localparam int ARB_RR     = 1;
    localparam int MAX_BE_W   = 64;
    localparam int MAX_DATA_W = MAX_BE_W * 8;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IF,
        GNT_D
    } grant_t;

    // Widens each byte-enable bit over its 8 data bits; bits at or above data_w stay 0.
    function automatic logic [MAX_DATA_W-1:0] be_expand(input logic [MAX_BE_W-1:0] be,
                                                        input int data_w);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < data_w) m[i] = be[i / 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/memaccess_ram.sv
// Single-port word RAM: synchronous read, bit-masked write, one access per cycle.
module memaccess_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wmask,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/memaccess_arb.sv
// Fetch/data port arbiter in front of a shared single-port RAM with 1-cycle read latency.
module memaccess_arb
    import memaccess_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int ARB_MODE = ARB_FIXED
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic                if_valid,
    output logic [DATA_W-1:0]   ir,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ready,
    output logic                d_valid,
    output logic [DATA_W-1:0]   q
);

    grant_t              grant_p0;
    grant_t              last_winner;
    logic                conflict_p0;
    logic                in_range_p0;
    logic                ram_en_p0;
    logic                ram_we_p0;
    logic [ADDR_W-1:0]   addr_p0;
    logic [DATA_W-1:0]   wmask_p0;
    logic                vld_if_p1;
    logic                vld_d_p1;
    logic                in_range_p1;
    logic [DATA_W-1:0]   rdata_p1;
    logic [DATA_W-1:0]   rd_p1;
    logic [DATA_W-1:0]   ir_hold;
    logic [DATA_W-1:0]   q_hold;

    // Stage p0: grant, address select and RAM command
    always_comb begin
        grant_p0 = GNT_NONE;
        if (!rst) begin
            if (if_req && d_req) begin
                // Round-robin hands the conflict to whoever lost the previous one
                if (ARB_MODE == ARB_RR && last_winner == GNT_D) grant_p0 = GNT_IF;
                else                                             grant_p0 = GNT_D;
            end else if (d_req) begin
                grant_p0 = GNT_D;
            end else if (if_req) begin
                grant_p0 = GNT_IF;
            end
        end
    end

    assign conflict_p0 = if_req && d_req && !rst;
    assign addr_p0     = (grant_p0 == GNT_D) ? d_addr : if_addr;
    assign in_range_p0 = int'(addr_p0) < DEPTH;
    assign ram_en_p0   = (grant_p0 != GNT_NONE) && in_range_p0;
    assign ram_we_p0   = (grant_p0 == GNT_D) && d_we;
    assign wmask_p0    = DATA_W'(be_expand(MAX_BE_W'(d_be), DATA_W));

    assign if_ready = (grant_p0 == GNT_IF);
    assign d_ready  = (grant_p0 == GNT_D);

    memaccess_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_p0),
        .we    (ram_we_p0),
        .addr  (addr_p0),
        .wmask (wmask_p0),
        .wdata (d_wdata),
        .rdata (rdata_p1)
    );

    // Stage p1: read-valid tracking and held outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_if_p1   <= 1'b0;
            vld_d_p1    <= 1'b0;
            last_winner <= GNT_D;
            ir_hold     <= '0;
            q_hold      <= '0;
        end else begin
            vld_if_p1 <= (grant_p0 == GNT_IF);
            vld_d_p1  <= (grant_p0 == GNT_D) && !d_we;
            if (conflict_p0) last_winner <= grant_p0;
            ir_hold   <= ir;
            q_hold    <= q;
        end
    end

    always_ff @(posedge clk) begin
        in_range_p1 <= in_range_p0;
    end

    // A read caught by an asserting rst is squashed before it reaches the ports
    assign rd_p1    = in_range_p1 ? rdata_p1 : '0;
    assign if_valid = vld_if_p1 && !rst;
    assign d_valid  = vld_d_p1 && !rst;
    assign ir       = rst ? '0 : (if_valid ? rd_p1 : ir_hold);
    assign q        = rst ? '0 : (d_valid ? rd_p1 : q_hold);

endmodule
